// File: rtl/ctl_7seg9_pkg.sv
// Shared constants, state encoding and segment table for the 9-digit display controller.
package ctl_7seg9_pkg;

  localparam int unsigned NUM_DIGITS = 9;
  localparam int unsigned LED_W      = 8 * NUM_DIGITS;

  localparam logic [7:0] CMD_DATA = 8'h40;  // write data, auto-increment address
  localparam logic [7:0] CMD_ADDR = 8'hC0;  // set address 0
  localparam logic [7:0] CMD_DISP = 8'h80;  // display control, OR'd with on/level

  typedef enum logic [2:0] {
    IDLE_RST,
    START,
    BITS,
    STOP,
    GAP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    FRAME_DATA,
    FRAME_ADDR,
    FRAME_DISP
  } frame_e;

  // Segments a..g for a 5-bit code; codes 16 and 18..31 are blank, 17 is a dash.
  function automatic logic [6:0] seg_lookup(input logic [4:0] value);
    logic [6:0] seg;
    case (value)
      5'd0:    seg = 7'h3F;
      5'd1:    seg = 7'h06;
      5'd2:    seg = 7'h5B;
      5'd3:    seg = 7'h4F;
      5'd4:    seg = 7'h66;
      5'd5:    seg = 7'h6D;
      5'd6:    seg = 7'h7D;
      5'd7:    seg = 7'h07;
      5'd8:    seg = 7'h7F;
      5'd9:    seg = 7'h6F;
      5'd10:   seg = 7'h77;
      5'd11:   seg = 7'h7C;
      5'd12:   seg = 7'h39;
      5'd13:   seg = 7'h5E;
      5'd14:   seg = 7'h79;
      5'd15:   seg = 7'h71;
      5'd17:   seg = 7'h40;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ctl_7seg9_hexdigit.sv
// Leaf encoder: 5-bit digit code plus decimal point to a segment byte.
import ctl_7seg9_pkg::*;

module hexdigit (
  input  logic [4:0] value,
  input  logic       dp,
  output logic [7:0] seg
);

  // Bit 7 carries the decimal point, bits 6:0 the a..g segments.
  assign seg = {dp, seg_lookup(value)};

endmodule

// File: rtl/ctl_7seg9.sv
// One-shot refresh of a 9-digit TM1640-style display after each reset release.
import ctl_7seg9_pkg::*;

module ctl_7seg9 #(
  parameter int unsigned HALF_PERIOD = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] led_data_packed,
  input  logic [2:0]       level,
  input  logic             on,
  output logic             tm_clk,
  output logic             tm_din,
  output logic             tm_busy
);

  localparam int unsigned CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  state_e           state_q, state_d;
  frame_e           frame_q, frame_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [2:0]       level_q, level_d;
  logic             on_q, on_d;
  logic             clk_q, clk_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             half_end;
  logic [3:0]       digit_idx;
  logic [6:0]       digit_base;
  logic [7:0]       tx_byte;

  assign half_end = (cnt_q == CNT_W'(HALF_PERIOD - 1));

  // Sequencer: half-period timer steps phases, phases step bits, bytes and frames.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    led_d   = led_q;
    level_d = level_q;
    on_d    = on_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE_RST: begin
        led_d   = led_data_packed;
        level_d = level;
        on_d    = on;
        busy_d  = 1'b1;
        state_d = START;
        frame_d = FRAME_DATA;
        phase_d = 2'd0;
        cnt_d   = '0;
      end
      DONE: ;
      default: begin
        if (!half_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          phase_d = phase_q + 2'd1;
          case (state_q)
            START: if (phase_q == 2'd1) begin
              state_d = BITS;
              phase_d = 2'd0;
              bit_d   = 3'd0;
              byte_d  = 4'd0;
            end
            BITS: if (phase_q == 2'd1) begin
              phase_d = 2'd0;
              if (bit_q != 3'd7) begin
                bit_d = bit_q + 3'd1;
              end else if (frame_q == FRAME_ADDR && byte_q != 4'(NUM_DIGITS)) begin
                bit_d  = 3'd0;
                byte_d = byte_q + 4'd1;
              end else begin
                state_d = STOP;
              end
            end
            STOP: if (phase_q == 2'd2) begin
              phase_d = 2'd0;
              if (frame_q == FRAME_DISP) begin
                state_d = DONE;
                busy_d  = 1'b0;
              end else begin
                state_d = GAP;
                frame_d = frame_e'(frame_q + 2'd1);
              end
            end
            GAP: if (phase_q == 2'd1) begin
              phase_d = 2'd0;
              state_d = START;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Byte on the wire for the upcoming position; byte 0 of the address frame is the command.
  always_comb begin
    digit_idx  = (byte_d == 4'd0) ? 4'd0 : byte_d - 4'd1;
    digit_base = {digit_idx, 3'b000};
    case (frame_d)
      FRAME_DATA: tx_byte = CMD_DATA;
      FRAME_ADDR: tx_byte = (byte_d == 4'd0) ? CMD_ADDR : led_q[digit_base +: 8];
      default:    tx_byte = CMD_DISP | {4'b0000, on_q, level_q};
    endcase
  end

  // Line levels for the next state/phase, so tm_clk/tm_din are registered.
  always_comb begin
    clk_d = 1'b1;
    din_d = 1'b1;
    case (state_d)
      START: begin
        clk_d = (phase_d == 2'd0);
        din_d = 1'b0;
      end
      BITS: begin
        clk_d = (phase_d == 2'd1);
        din_d = tx_byte[bit_d];
      end
      STOP: begin
        clk_d = (phase_d != 2'd0);
        din_d = (phase_d == 2'd2);
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any transfer with both lines high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_RST;
      frame_q <= FRAME_DATA;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      led_q   <= '0;
      level_q <= 3'd0;
      on_q    <= 1'b0;
      clk_q   <= 1'b1;
      din_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      led_q   <= led_d;
      level_q <= level_d;
      on_q    <= on_d;
      clk_q   <= clk_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign tm_clk  = clk_q;
  assign tm_din  = din_q;
  assign tm_busy = busy_q;

endmodule

// File: tb/tb_ctl_7seg9.sv
// Directed bench: decodes the 2-wire stream into bytes and checks frames, timing and hexdigit.
`timescale 1ns/1ps

module tb_ctl_7seg9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] led_data_packed = '0;
  logic [2:0]  level = 3'd0;
  logic        on = 1'b0;
  logic        tm_clk, tm_din, tm_busy;
  logic [4:0]  hd_value = '0;
  logic        hd_dp = 1'b0;
  logic [7:0]  hd_seg;

  int checks = 0;
  int errors = 0;

  ctl_7seg9 #(.HALF_PERIOD(6)) dut (
    .clk(clk), .rst(rst), .led_data_packed(led_data_packed), .level(level), .on(on),
    .tm_clk(tm_clk), .tm_din(tm_din), .tm_busy(tm_busy)
  );

  hexdigit u_hex (.value(hd_value), .dp(hd_dp), .seg(hd_seg));

  always #5 clk = ~clk;

  // Line decoder: START/STOP by data edges while clock high, bits on clock rise.
  logic [7:0] got[$];
  int starts = 0;
  int stops = 0;
  int nb = 0;
  logic [7:0] sh = '0;
  logic pclk = 1'b1;
  logic pdin = 1'b1;

  always @(negedge clk) begin
    if (tm_clk && pclk && pdin && !tm_din) begin starts++; nb = 0; end
    if (tm_clk && pclk && !pdin && tm_din) stops++;
    if (tm_clk && !pclk) begin
      sh = {tm_din, sh[7:1]};
      nb++;
      if (nb == 8) begin got.push_back(sh); nb = 0; end
    end
    pclk = tm_clk;
    pdin = tm_din;
  end

  logic [7:0] exp_b[12];

  task automatic set_exp(input logic [71:0] led, input logic o, input logic [2:0] l);
    exp_b[0] = 8'h40;
    exp_b[1] = 8'hC0;
    for (int k = 0; k < 9; k++) exp_b[2+k] = led[8*k +: 8];
    exp_b[11] = 8'h80 | {4'b0000, o, l};
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_refresh();
    @(negedge clk);
    got.delete();
    starts = 0;
    stops = 0;
    nb = 0;
    rst = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    int n;
    bc = 0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (tm_busy) bc++;
      else if (bc > 0) break;
    end
    if (n == 3000) begin
      checks++; errors++;
      $display("FAIL busy_timeout got busy_cycles %0d exp completion", bc);
    end
  endtask

  task automatic test_reset();
    int bc;
    logic [7:0] act;
    led_data_packed = '0; level = 3'd4; on = 1'b1;
    hold_reset();
    #2;
    checks++; if (tm_clk !== 1'b1)  begin errors++; $display("FAIL rst_clk got %b exp 1", tm_clk); end
    checks++; if (tm_din !== 1'b1)  begin errors++; $display("FAIL rst_din got %b exp 1", tm_din); end
    checks++; if (tm_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", tm_busy); end
    set_exp('0, 1'b1, 3'd4);
    start_refresh();
    wait_done(bc);
    checks++; if (bc !== 1266) begin errors++; $display("FAIL busy_len got %0d exp 1266", bc); end
    checks++; if (got.size() !== 12) begin errors++; $display("FAIL byte_count got %0d exp 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp_b[i]) begin errors++; $display("FAIL zero_byte%0d got %h exp %h", i, act, exp_b[i]); end
    end
    checks++; if (starts !== 3) begin errors++; $display("FAIL starts got %0d exp 3", starts); end
    checks++; if (stops !== 3)  begin errors++; $display("FAIL stops got %0d exp 3", stops); end
    repeat (20) @(negedge clk);
    checks++; if ({tm_clk, tm_din, tm_busy} !== 3'b110) begin
      errors++; $display("FAIL done_lines got %b exp 110", {tm_clk, tm_din, tm_busy});
    end
  endtask

  task automatic test_digits();
    int bc;
    logic [7:0] act;
    led_data_packed = {8'h6F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    level = 3'd4; on = 1'b1;
    hold_reset();
    set_exp(led_data_packed, 1'b1, 3'd4);
    start_refresh();
    wait_done(bc);
    for (int i = 0; i < 12; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp_b[i]) begin errors++; $display("FAIL digit_byte%0d got %h exp %h", i, act, exp_b[i]); end
    end
  endtask

  task automatic test_input_change();
    int bc;
    logic [7:0] act;
    logic [71:0] orig;
    orig = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h5A};
    led_data_packed = orig; level = 3'd4; on = 1'b1;
    hold_reset();
    set_exp(orig, 1'b1, 3'd4);
    start_refresh();
    repeat (100) @(negedge clk);
    level = 3'd7; on = 1'b0; led_data_packed = '1;
    wait_done(bc);
    for (int i = 0; i < 12; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp_b[i]) begin errors++; $display("FAIL shadow_byte%0d got %h exp %h", i, act, exp_b[i]); end
    end
  endtask

  task automatic test_on_level();
    int bc;
    logic [7:0] act;
    led_data_packed = '0; level = 3'd7; on = 1'b0;
    hold_reset();
    start_refresh();
    wait_done(bc);
    act = (got.size() == 12) ? got[11] : 8'hxx;
    checks++; if (act !== 8'h87) begin errors++; $display("FAIL disp_off7 got %h exp 87", act); end
    level = 3'd0; on = 1'b1;
    hold_reset();
    start_refresh();
    wait_done(bc);
    act = (got.size() == 12) ? got[11] : 8'hxx;
    checks++; if (act !== 8'h88) begin errors++; $display("FAIL disp_on0 got %h exp 88", act); end
  endtask

  task automatic test_abort();
    int bc;
    int n;
    logic [7:0] act;
    led_data_packed = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    level = 3'd2; on = 1'b1;
    hold_reset();
    set_exp(led_data_packed, 1'b1, 3'd2);
    start_refresh();
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (got.size() >= 3) break;
    end
    checks++; if (got.size() < 3) begin errors++; $display("FAIL abort_reach got %0d bytes exp >=3", got.size()); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({tm_clk, tm_din, tm_busy} !== 3'b110) begin
      errors++; $display("FAIL abort_lines got %b exp 110", {tm_clk, tm_din, tm_busy});
    end
    repeat (4) @(negedge clk);
    start_refresh();
    wait_done(bc);
    checks++; if (bc !== 1266) begin errors++; $display("FAIL restart_len got %0d exp 1266", bc); end
    for (int i = 0; i < 12; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp_b[i]) begin errors++; $display("FAIL restart_byte%0d got %h exp %h", i, act, exp_b[i]); end
    end
  endtask

  task automatic test_hexdigit();
    logic [7:0] tbl[16];
    logic [7:0] expv;
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    for (int v = 0; v < 32; v++) begin
      for (int d = 0; d < 2; d++) begin
        hd_value = 5'(v);
        hd_dp = 1'(d);
        #1;
        expv = (v < 16) ? tbl[v] : ((v == 17) ? 8'h40 : 8'h00);
        expv[7] = 1'(d);
        checks++;
        if (hd_seg !== expv) begin errors++; $display("FAIL hex_v%0d_dp%0d got %h exp %h", v, d, hd_seg, expv); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_input_change();
    test_on_level();
    test_abort();
    test_hexdigit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
